psc_pkt_arbiter: RTL and testbench
==================================

// Module: psc_pkt_arbiter
// PURPOSE
//  Round-robin, packet-atomic arbiter. Shares one flagged packet channel among N requesters.
//  Each requester supplies DATA_WIDTH+1-bit words: MSB=1 marks head and tail, MSB=0 marks a middle word.
//  A packet is at least 2 words; the second flagged word is the tail.
//  Forwards one whole packet at a time to the single downstream consumer.
//  Guards against stalled or malformed senders with an idle timeout and a maximum-length cap.
// PARAMETERS
//  DATA_WIDTH   8     payload width; words are DATA_WIDTH+1 bits including the flag
//  N_PORTS      4     requesters, 2..16
//  TIMEOUT      255   max consecutive idle cycles while granted before forced release
//  MAX_LEN      1024  max words per packet including head and tail
// PORTS
//  i_clk          in   1                     clock, rising edge
//  i_rst_n        in   1                     synchronous, active-low reset
//  iv_req         in   N_PORTS               per-port packet-pending request, level
//  iv_data        in   N_PORTS*(DATA_WIDTH+1) port p occupies bits [p*(DW+1)+:DW+1]
//  iv_data_wr     in   N_PORTS               per-port word strobe
//  ov_grant       out  N_PORTS               one-hot grant, registered
//  ov_data        out  DATA_WIDTH+1          forwarded word, flag kept in the MSB
//  o_data_wr      out  1                     forwarded word strobe
//  ov_active_port out  clog2(N_PORTS)        index of the granted port; valid while o_busy=1
//  o_busy         out  1                     high in GRANT and XFER
//  o_err_timeout  out  1                     1-cycle pulse on forced release
//  o_err_proto    out  1                     1-cycle pulse on headless word or length cap hit
// BEHAVIOUR
//  Reset (i_rst_n=0 at a clock edge):
//   - all outputs 0; state=IDLE; rr_ptr=0; counters=0.
//   - A reset mid-packet truncates the packet silently. No tail is emitted.
//  Latency: a granted input word appears on ov_data/o_data_wr exactly 1 cycle later.
//  Non-granted strobes are ignored and dropped. Senders hold data until they see their ov_grant bit.
//  States:
//   IDLE:
//    - If iv_req!=0, pick the first requesting port scanning rr_ptr, rr_ptr+1, .. mod N.
//    - Register sel, set ov_grant[sel], go GRANT.
//    - If iv_req==0, stay in IDLE.
//   GRANT (waiting for head):
//    - wr with flag=1: forward it, word_cnt=1, go XFER.
//    - wr with flag=0: drop it, pulse o_err_proto, stay in GRANT.
//    - No wr: idle_cnt++.
//   XFER:
//    - Each wr is forwarded and increments word_cnt.
//    - A flag=1 word is the tail: forward it, go GAP.
//    - Gaps in wr are legal; idle_cnt++ per idle cycle, cleared on every wr.
//    - If word_cnt reaches MAX_LEN-1 and the next word has flag=0: forward it with MSB forced to 1,
//      pulse o_err_proto, go GAP. Downstream always sees a terminated packet.
//   Timeout (GRANT or XFER, when idle_cnt==TIMEOUT):
//    - Pulse o_err_timeout, go GAP.
//    - From XFER no tail is synthesised; downstream handles the truncated packet.
//   GAP:
//    - ov_grant=0, o_busy=0, rr_ptr<=(sel+1) mod N, counters cleared, go IDLE.
//    - This gives a mandatory 1-cycle bubble, so back-to-back grants are >=2 cycles apart.
//  Simultaneous events:
//   - A tail and the timeout on the same cycle: the tail wins, no error.
//   - A tail on the MAX_LEN-th word: normal end, no error.
//   - iv_req dropping while granted has no effect. Release happens only by tail, timeout or cap.
//  Counter widths: clog2(TIMEOUT+1) and clog2(MAX_LEN+1). Neither counter wraps; both saturate at terminal.
// STRUCTURE
//  - psc_defs.vh (shared): state encodings IDLE=2'b00, GRANT=2'b01, XFER=2'b10, GAP=2'b11;
//    the FLAG_BIT position macro; the clog2 function.
//  - Sub-module psc_rr_pick: combinational round-robin picker.
//    Inputs: req[N], ptr. Outputs: one-hot grant, index, any.
//  - Top holds the FSM, counters, per-port mux and output registers.
// TESTING
//  1 Reset: hold i_rst_n=0 for 3 clocks with iv_req=4'hF -> all outputs 0; first grant after release goes to port 0.
//  2 Round-robin: iv_req=4'b1011, each port sends a 3-word packet 0x1AA,0x055,0x1BB -> grant order 0,1,3,0.
//    Each packet appears 1 cycle later, unchanged; 1 idle cycle between packets.
//  3 Headless: granted port 2 sends 0x011 (flag=0) then 0x1C0,0x1C1 -> 0x011 dropped, o_err_proto pulses once,
//    output is 0x1C0,0x1C1.
//  4 Timeout: TIMEOUT=8, grant port 1 with no wr for 8 cycles -> o_err_timeout pulses on the 8th idle cycle,
//    grant drops, next grant goes to port 2 if it is requesting.
//  5 Length cap: MAX_LEN=4, packet 0x1A0,0x0A1,0x0A2,0x0A3,0x0A4 -> output 0x1A0,0x0A1,0x0A2,0x1A3;
//    o_err_proto pulses; 0x0A4 is dropped.
//  6 Reset mid-XFER: assert i_rst_n=0 after the 2nd word -> o_data_wr=0 the next cycle, no tail emitted, rr_ptr=0.

Source files
------------

// File: rtl/psc_pkt_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter.
package psc_pkt_arbiter_pkg;

   // Arbiter FSM states; encodings are fixed so they read the same in waveforms.
   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StGrant = 2'b01,
      StXfer  = 2'b10,
      StGap   = 2'b11
   } state_e;

   // Bits needed for a counter that must hold values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/psc_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_PORTS.
module psc_pkt_arbiter_rr_pick
   import psc_pkt_arbiter_pkg::*;
#(
   parameter int unsigned N_PORTS = 4,
   parameter int unsigned PW      = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [N_PORTS-1:0] grant,
   output logic [PW-1:0]      idx,
   output logic               any
);

   // Scan ptr, ptr+1, ... and latch the first requester found.
   always_comb begin
      logic [PW-1:0] cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         cand = PW'((32'(ptr) + i) % N_PORTS);
         if (!any && req[cand]) begin
            any         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/psc_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: grants one requester at a time and forwards its
// flagged words (MSB marks head/tail) with one cycle of latency. Stalled senders are
// released by an idle timeout; runaway packets are cut at MAX_LEN with a forced tail.
module psc_pkt_arbiter
   import psc_pkt_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned N_PORTS    = 4,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned MAX_LEN    = 1024
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [N_PORTS-1:0]                iv_req,
   input  logic [N_PORTS*(DATA_WIDTH+1)-1:0] iv_data,
   input  logic [N_PORTS-1:0]                iv_data_wr,
   output logic [N_PORTS-1:0]                ov_grant,
   output logic [DATA_WIDTH:0]               ov_data,
   output logic                              o_data_wr,
   output logic [$clog2(N_PORTS)-1:0]        ov_active_port,
   output logic                              o_busy,
   output logic                              o_err_timeout,
   output logic                              o_err_proto
);

   localparam int unsigned WW   = DATA_WIDTH + 1;
   localparam int unsigned FLAG = DATA_WIDTH;
   localparam int unsigned PW   = $clog2(N_PORTS);
   localparam int unsigned TW   = cnt_width(TIMEOUT);
   localparam int unsigned LW   = cnt_width(MAX_LEN);

   state_e               state_q, state_d;
   logic [PW-1:0]        sel_q, sel_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [N_PORTS-1:0]   grant_q, grant_d;
   logic [TW-1:0]        idle_q, idle_d, idle_inc;
   logic [LW-1:0]        word_q, word_d, word_inc;
   logic [WW-1:0]        data_q, data_d;
   logic                 data_wr_q, data_wr_d;
   logic                 err_to_q, err_to_d;
   logic                 err_proto_q, err_proto_d;

   logic [N_PORTS-1:0]   pick_grant;
   logic [PW-1:0]        pick_idx;
   logic                 pick_any;
   logic [WW-1:0]        port_word [N_PORTS];
   logic [WW-1:0]        cur_word;
   logic                 cur_wr;

   psc_pkt_arbiter_rr_pick #(
      .N_PORTS (N_PORTS),
      .PW      (PW)
   ) u_rr_pick (
      .req   (iv_req),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   for (genvar g = 0; g < N_PORTS; g++) begin : g_port_word
      assign port_word[g] = iv_data[g*WW +: WW];
   end

   assign cur_word = port_word[sel_q];
   assign cur_wr   = iv_data_wr[sel_q];

   // Both counters saturate at their terminal value instead of wrapping.
   assign idle_inc = (idle_q == TW'(TIMEOUT)) ? idle_q : idle_q + TW'(1);
   assign word_inc = (word_q == LW'(MAX_LEN)) ? word_q : word_q + LW'(1);

   // Next-state, counter and output-register decode.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      idle_d      = idle_q;
      word_d      = word_q;
      data_d      = data_q;
      data_wr_d   = 1'b0;
      err_to_d    = 1'b0;
      err_proto_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               sel_d   = pick_idx;
               grant_d = pick_grant;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (cur_wr) begin
               idle_d = '0;
               if (cur_word[FLAG]) begin
                  data_d    = cur_word;
                  data_wr_d = 1'b1;
                  word_d    = LW'(1);
                  state_d   = StXfer;
               end else begin
                  err_proto_d = 1'b1;  // headless word is dropped
               end
            end else begin
               idle_d = idle_inc;
               if (idle_inc == TW'(TIMEOUT)) begin
                  err_to_d = 1'b1;
                  grant_d  = '0;
                  state_d  = StGap;
               end
            end
         end
         StXfer: begin
            if (cur_wr) begin
               idle_d    = '0;
               data_d    = cur_word;
               data_wr_d = 1'b1;
               word_d    = word_inc;
               if (cur_word[FLAG]) begin
                  grant_d = '0;
                  state_d = StGap;
               end else if (word_q == LW'(MAX_LEN - 1)) begin
                  // Length cap: terminate the packet so downstream never sees it open.
                  data_d[FLAG] = 1'b1;
                  err_proto_d  = 1'b1;
                  grant_d      = '0;
                  state_d      = StGap;
               end
            end else begin
               idle_d = idle_inc;
               if (idle_inc == TW'(TIMEOUT)) begin
                  err_to_d = 1'b1;
                  grant_d  = '0;
                  state_d  = StGap;
               end
            end
         end
         StGap: begin
            rr_ptr_d = (sel_q == PW'(N_PORTS - 1)) ? '0 : sel_q + PW'(1);
            idle_d   = '0;
            word_d   = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         idle_q      <= '0;
         word_q      <= '0;
         data_q      <= '0;
         data_wr_q   <= 1'b0;
         err_to_q    <= 1'b0;
         err_proto_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         idle_q      <= idle_d;
         word_q      <= word_d;
         data_q      <= data_d;
         data_wr_q   <= data_wr_d;
         err_to_q    <= err_to_d;
         err_proto_q <= err_proto_d;
      end
   end

   assign ov_grant       = grant_q;
   assign ov_data        = data_q;
   assign o_data_wr      = data_wr_q;
   assign ov_active_port = sel_q;
   assign o_busy         = (state_q == StGrant) || (state_q == StXfer);
   assign o_err_timeout  = err_to_q;
   assign o_err_proto    = err_proto_q;

endmodule

// File: tb/tb_psc_pkt_arbiter.sv
// Scoreboard bench for psc_pkt_arbiter: stimulus pushes expected words, error pulses and
// grants into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_psc_pkt_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned NP = 4;
   localparam int unsigned TO = 8;
   localparam int unsigned ML = 4;
   localparam int unsigned WW = DW + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NP-1:0]     iv_req = '0;
   logic [NP*WW-1:0]  iv_data = '0;
   logic [NP-1:0]     iv_data_wr = '0;
   logic [NP-1:0]     ov_grant;
   logic [DW:0]       ov_data;
   logic              o_data_wr;
   logic [1:0]        ov_active_port;
   logic              o_busy;
   logic              o_err_timeout;
   logic              o_err_proto;

   int                n_checks = 0;
   int                n_pass = 0;
   int                cyc = 0;
   int                grant_cyc = 0;
   logic [NP-1:0]     prev_grant = '0;
   logic [10:0]       exp_q[$];        // {kind, word}: kind 0=word, 1=proto err, 2=timeout
   int                exp_grant_q[$];
   logic [8:0]        pkt[$];

   always #5 clk = ~clk;

   psc_pkt_arbiter #(
      .DATA_WIDTH (DW),
      .N_PORTS    (NP),
      .TIMEOUT    (TO),
      .MAX_LEN    (ML)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .iv_req         (iv_req),
      .iv_data        (iv_data),
      .iv_data_wr     (iv_data_wr),
      .ov_grant       (ov_grant),
      .ov_data        (ov_data),
      .o_data_wr      (o_data_wr),
      .ov_active_port (ov_active_port),
      .o_busy         (o_busy),
      .o_err_timeout  (o_err_timeout),
      .o_err_proto    (o_err_proto)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic missing(input string name);
      n_checks++;
      $display("FAIL %s: got an event, expected none", name);
   endtask

   task automatic push_word(input logic [8:0] w);
      exp_q.push_back({2'd0, w});
   endtask

   // Monitor: compare every forwarded word, error pulse and grant onset.
   always @(negedge clk) begin
      logic [10:0] e;
      int g;
      cyc++;
      if (o_data_wr) begin
         if (exp_q.size() == 0) missing("unexpected_word");
         else begin
            e = exp_q.pop_front();
            check("out_word", {21'd0, 2'd0, ov_data}, {21'd0, e});
         end
      end
      if (o_err_proto) begin
         if (exp_q.size() == 0) missing("unexpected_err_proto");
         else begin
            e = exp_q.pop_front();
            check("err_proto", {21'd0, 2'd1, 9'd0}, {21'd0, e});
         end
      end
      if (o_err_timeout) begin
         if (exp_q.size() == 0) missing("unexpected_err_timeout");
         else begin
            e = exp_q.pop_front();
            check("err_timeout", {21'd0, 2'd2, 9'd0}, {21'd0, e});
            check("timeout_latency", cyc - grant_cyc, TO);
         end
      end
      if (ov_grant != '0 && prev_grant == '0) begin
         grant_cyc = cyc;
         if (exp_grant_q.size() == 0) missing("unexpected_grant");
         else begin
            g = exp_grant_q.pop_front();
            check("grant", ov_grant, 1 << g);
            check("active_port", ov_active_port, g);
            check("busy_on_grant", o_busy, 1);
         end
      end
      prev_grant = ov_grant;
   end

   task automatic wait_grant(input int p);
      bit got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (ov_grant[p]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) missing($sformatf("grant_wait_port%0d", p));
   endtask

   // Drive pkt on port p one word per cycle; a non-granted port strobes junk alongside.
   task automatic drive_words(input int p);
      int noise;
      noise = (p + 2) % NP;
      foreach (pkt[i]) begin
         iv_data[p*WW +: WW]     = pkt[i];
         iv_data[noise*WW +: WW] = 9'h1EE;
         iv_data_wr              = '0;
         iv_data_wr[p]           = 1'b1;
         iv_data_wr[noise]       = 1'b1;
         @(posedge clk);
         #1;
      end
      iv_data_wr = '0;
   endtask

   task automatic send_pkt(input int p);
      iv_req[p] = 1'b1;
      wait_grant(p);
      iv_req[p] = 1'b0;   // dropping req while granted must not release
      drive_words(p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset with all ports requesting.
      iv_req = 4'hF;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", ov_grant, 0);
      check("rst_data", ov_data, 0);
      check("rst_data_wr", o_data_wr, 0);
      check("rst_busy", o_busy, 0);
      check("rst_active_port", ov_active_port, 0);
      check("rst_err_timeout", o_err_timeout, 0);
      check("rst_err_proto", o_err_proto, 0);

      // Round-robin over ports 0,1,3 then 0 again.
      exp_grant_q = '{0, 1, 3, 0};
      for (int k = 0; k < 4; k++) begin
         push_word(9'h1AA);
         push_word(9'h055);
         push_word(9'h1BB);
      end
      pkt   = '{9'h1AA, 9'h055, 9'h1BB};
      rst_n = 1'b1;
      wait_grant(0);
      iv_req = 4'b1010;
      drive_words(0);
      send_pkt(1);
      send_pkt(3);
      send_pkt(0);

      // Headless word on port 2 is dropped with a proto pulse.
      exp_grant_q.push_back(2);
      exp_q.push_back({2'd1, 9'd0});
      push_word(9'h1C0);
      push_word(9'h1C1);
      pkt = '{9'h011, 9'h1C0, 9'h1C1};
      send_pkt(2);

      // Port 1 stalls until timeout; port 2 is next even with port 1 still requesting.
      exp_grant_q.push_back(1);
      exp_grant_q.push_back(2);
      exp_q.push_back({2'd2, 9'd0});
      push_word(9'h1D0);
      push_word(9'h1D1);
      iv_req = 4'b0110;
      wait_grant(1);
      wait_grant(2);
      iv_req = '0;
      pkt = '{9'h1D0, 9'h1D1};
      drive_words(2);

      // Reset in the middle of a port 3 packet: no tail, pointer back to 0.
      exp_grant_q.push_back(3);
      push_word(9'h1B0);
      push_word(9'h0B1);
      iv_req = 4'b1000;
      wait_grant(3);
      iv_req = '0;
      pkt = '{9'h1B0, 9'h0B1};
      drive_words(3);
      rst_n                = 1'b0;
      iv_data[3*WW +: WW]  = 9'h0B2;
      iv_data_wr[3]        = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_data_wr", o_data_wr, 0);
      check("midrst_grant", ov_grant, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_data", ov_data, 0);
      iv_data_wr = '0;
      iv_req     = 4'b1010;
      rst_n      = 1'b1;
      exp_grant_q.push_back(1);
      push_word(9'h1E0);
      push_word(9'h1E1);
      wait_grant(1);
      iv_req = '0;
      pkt = '{9'h1E0, 9'h1E1};
      drive_words(1);

      // Length cap: 4th word gets a forced tail flag, 5th is dropped.
      exp_grant_q.push_back(3);
      push_word(9'h1A0);
      push_word(9'h0A1);
      push_word(9'h0A2);
      push_word(9'h1A3);
      exp_q.push_back({2'd1, 9'd0});
      pkt = '{9'h1A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4};
      send_pkt(3);

      repeat (6) @(posedge clk);
      #1;
      check("events_drained", exp_q.size(), 0);
      check("grants_drained", exp_grant_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
